fir_prefix_acc: RTL and testbench
=================================

Name: fir_prefix_acc

Overview:
- Accumulator controller for the FIR tap-sum path. It sits directly around the 32-bit prefix-carry network: it drives that network's per-bit kill/propagate/generate code vector and consumes the resolved group codes it returns.
- It accumulates TAPS products per output sample, one product per handshake.
- Sum bits are formed from the returned codes.
- The finished sum is presented on a valid/ready output.

Parameters:
- TAPS, 8, number of products accumulated per output sample (TAPS >= 1).
- CNT_W, $clog2(TAPS+1), width of the accepted-product counter (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new accumulation (honoured in IDLE only).
- in_valid  input  1  product valid.
- in_ready  output  1  block can take a product.
- in_data  input  32  unsigned product.
- ppc_x  output  [31:0][7:0]  per-bit code vector to the prefix network.
- ppc_y  input  [31:0][7:0]  resolved group codes from the prefix network (combinational return).
- out_valid  output  1  accumulated result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  accumulated sum.
- out_ovf  output  1  sticky carry-out flag (see Optional Feature).

Behaviour:
- Code bytes: KPG_K = 8'h6B ("k"), KPG_P = 8'h70 ("p"), KPG_G = 8'h67 ("g").
- ppc_x[i] is driven combinationally from registers acc[i] and b_reg[i]:
  - 0,0 -> K
  - 1,1 -> G
  - otherwise -> P
- Carry and sum rules:
  - c[0] = 0 (carry-in 0).
  - c[i] = (ppc_y[i-1] == KPG_G) for i = 1..31. Any byte other than G means carry 0.
  - sum[i] = acc[i] ^ b_reg[i] ^ c[i].
  - carry_out = (ppc_y[31] == KPG_G).
- Registers: state, acc[31:0], b_reg[31:0], b_vld, cnt[CNT_W-1:0], ovf.
- Reset (async, rst_n low): state = IDLE; acc, b_reg, cnt = 0; b_vld = 0; ovf = 0. Resulting outputs: in_ready = 0, out_valid = 0, out_data = 0, out_ovf = 0. Reset mid-accumulation discards all partial state.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - On start: acc, cnt, b_vld, ovf cleared; go to ACC.
- ACC:
  - in_ready = (cnt < TAPS).
  - Product accept (in_valid & in_ready): b_reg <= in_data, b_vld <= 1, cnt <= cnt + 1.
  - Add: when b_vld = 1, acc <= sum (wraps mod 2^32). If carry_out, ovf <= 1. b_vld clears unless a new product is accepted in the same cycle.
  - Back-to-back accepts are legal: the old b_reg is added while the new product loads. Full throughput is one product per cycle.
  - Transition: when cnt == TAPS and b_vld == 0, go to DONE.
- DONE:
  - out_valid = 1, out_data = acc, in_ready = 0.
  - acc and out_ovf hold stable while out_ready is low.
  - On out_ready: go to IDLE.
- start outside IDLE is ignored.
- Latency: out_valid rises 2 cycles after the clock edge that accepted the last product.
- out_data is registered (acc); no combinational path from in_data to out_data.

Optional Feature:
- Macro: FIR_ACC_OVF_EN.
- Defined: ovf is a sticky register, set on any add with carry_out. It is cleared by start or reset, and out_ovf = ovf.
- Undefined: the ovf register is not built and out_ovf is tied 0. Accumulation still wraps mod 2^32.

Decomposition:
- Package fir_pkg:
  - localparams KPG_K, KPG_P, KPG_G.
  - typedef kpg_vec_t = logic [31:0][7:0].
  - state enum {IDLE, ACC, DONE}.
- Sub-module kpg_encode: purely combinational a/b bit pairs -> kpg_vec_t. Reused by other adders in the filter.
- The block's testbench instantiates the existing prefix network between ppc_x and ppc_y.

Test Plan:
- TAPS=4, start, products 1, 2, 3, 4 back-to-back -> out_valid 2 cycles after 4th accept, out_data = 10, out_ovf = 0.
- Carry ripple: products 0x0000FFFF, 0x00000001 (TAPS=2) -> out_data = 0x00010000, all ppc_y[15:0] = G during the add.
- Overflow: products 0xFFFFFFFF, 0x00000002 (TAPS=2) -> out_data = 0x00000001. out_ovf = 1 with FIR_ACC_OVF_EN, 0 without.
- Backpressure:
  - in_valid gapped (toggled every other cycle) -> same result as back-to-back.
  - out_ready low for 5 cycles in DONE -> out_data and out_valid held.
  - in_ready = 0 throughout DONE.
- Reset mid-op: assert rst_n = 0 after 2 of 4 products -> all outputs 0 immediately.
  - Next start then products 5, 5, 5, 5 -> out_data = 20.
- start pulsed during ACC and DONE -> ignored; result unchanged; in_ready drops after TAPS accepts.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared kill/propagate/generate codes, code vector type and accumulator states
package fir_pkg;

  localparam logic [7:0] KPG_K = 8'h6B;
  localparam logic [7:0] KPG_P = 8'h70;
  localparam logic [7:0] KPG_G = 8'h67;

  typedef logic [31:0][7:0] kpg_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/kpg_encode.sv
// rtl/kpg_encode.sv - combinational per-bit kill/propagate/generate encoder for two 32-bit operands
module kpg_encode
  import fir_pkg::*;
(
  input  logic [31:0]      a_i,
  input  logic [31:0]      b_i,
  output logic [31:0][7:0] kpg_o
);

  always_comb begin
    kpg_o = '0;
    for (int i = 0; i < 32; i++) begin
      if (!a_i[i] && !b_i[i]) begin
        kpg_o[i] = KPG_K;
      end else if (a_i[i] && b_i[i]) begin
        kpg_o[i] = KPG_G;
      end else begin
        kpg_o[i] = KPG_P;
      end
    end
  end

endmodule

// File: rtl/fir_prefix_acc.sv
// rtl/fir_prefix_acc.sv - TAPS-product accumulator wrapped around an external 32-bit prefix-carry network
// Optional sticky carry-out flag built only when FIR_ACC_OVF_EN is defined.
module fir_prefix_acc
  import fir_pkg::*;
#(
  parameter int TAPS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0][7:0] ppc_x,
  input  logic [31:0][7:0] ppc_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(TAPS);

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      b_reg_q, b_reg_d;
  logic             b_vld_q, b_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] carry;
  logic [31:0] sum;
  logic        carry_out;
  logic        accept;

  kpg_encode u_kpg_encode (
    .a_i   (acc_q),
    .b_i   (b_reg_q),
    .kpg_o (ppc_x)
  );

  // Carry into bit i is the resolved group code of bits [i-1:0]; anything but G is no carry.
  always_comb begin
    carry = '0;
    for (int i = 1; i < 32; i++) begin
      carry[i] = (ppc_y[i-1] == KPG_G);
    end
  end

  assign sum       = acc_q ^ b_reg_q ^ carry;
  assign carry_out = (ppc_y[31] == KPG_G);
  assign out_data  = acc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    b_reg_d   = b_reg_q;
    b_vld_d   = b_vld_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          b_vld_d = 1'b0;
          state_d = ACC;
        end
      end
      ACC: begin
        in_ready = (cnt_q < TAPS_C);
        accept   = in_valid && in_ready;
        // The pending product is summed while the next one loads into b_reg.
        if (b_vld_q) begin
          acc_d = sum;
        end
        b_vld_d = accept;
        if (accept) begin
          b_reg_d = in_data;
          cnt_d   = cnt_q + CNT_W'(1);
        end
        if ((cnt_q == TAPS_C) && !b_vld_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_reg_q <= '0;
      b_vld_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_reg_q <= b_reg_d;
      b_vld_q <= b_vld_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIR_ACC_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == IDLE) && start) begin
      ovf_d = 1'b0;
    end else if ((state_q == ACC) && b_vld_q && carry_out) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`else
  logic unused_carry_out;
  assign unused_carry_out = carry_out;
  assign out_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_fir_prefix_acc.sv
// tb/tb_fir_prefix_acc.sv - randomized bench for fir_prefix_acc with a behavioural prefix network and sum model
module tb_fir_prefix_acc;
  import fir_pkg::*;

  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  kpg_vec_t    ppc_x;
  kpg_vec_t    ppc_y;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] prod[$];
  logic        saw_ripple;
  logic [7:0]  grp_m;

  always #5 clk = ~clk;

  fir_prefix_acc #(.TAPS(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ppc_x     (ppc_x),
    .ppc_y     (ppc_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  // Prefix network: group code of bits [i:0] is the nearest non-propagate code at or below i.
  always_comb begin
    ppc_y = '0;
    grp_m = ppc_x[0];
    ppc_y[0] = grp_m;
    for (int i = 1; i < 32; i++) begin
      if (ppc_x[i] != KPG_P) grp_m = ppc_x[i];
      ppc_y[i] = grp_m;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ripple_now();
    bit all_g;
    all_g = 1'b1;
    for (int i = 0; i < 16; i++) if (ppc_y[i] != KPG_G) all_g = 1'b0;
    return all_g;
  endfunction

  task automatic run_sample(input bit gap, input int hold, input bit poke_start, input bit check_ripple);
    logic [63:0] total;
    logic [31:0] exp_data;
    logic        exp_ovf;
    int          idx;
    int          cyc;
    int          lat;
    bit          acc;
    total = '0;
    foreach (prod[i]) total += 64'(prod[i]);
    exp_data = total[31:0];
`ifdef FIR_ACC_OVF_EN
    exp_ovf = (total[63:32] != 0);
`else
    exp_ovf = 1'b0;
`endif
    saw_ripple = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_start", in_ready, 1);
    idx = 0;
    cyc = 0;
    while (idx < prod.size() && cyc < 100) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data  = prod[idx];
      start    = poke_start && (cyc == 1);
      acc      = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
      if (ripple_now()) saw_ripple = 1'b1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("all_products_taken", idx, prod.size());
    check("in_ready_after_taps", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ripple_now()) saw_ripple = 1'b1;
    end
    check("latency", lat, 2);
    check("out_data", out_data, exp_data);
    check("out_ovf", out_ovf, exp_ovf);
    if (check_ripple) check("ripple_all_g", saw_ripple, 1);
    for (int h = 0; h < hold; h++) begin
      start = poke_start;
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_data);
      check("hold_ovf", out_ovf, exp_ovf);
      check("hold_in_ready", in_ready, 0);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;

    prod = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_sample(1'b0, 0, 1'b0, 1'b0);
    prod = '{32'h0000FFFF, 32'h00000001, 32'h0, 32'h0};
    run_sample(1'b0, 0, 1'b0, 1'b1);
    prod = '{32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0};
    run_sample(1'b0, 1, 1'b0, 1'b0);
    prod = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_sample(1'b1, 5, 1'b0, 1'b0);
    prod = '{32'd7, 32'd8, 32'd9, 32'd10};
    run_sample(1'b0, 3, 1'b1, 1'b0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hFFFFFFF0;
    @(negedge clk);
    in_data = 32'h00000100;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prod = '{32'd5, 32'd5, 32'd5, 32'd5};
    run_sample(1'b0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      prod.delete();
      for (int k = 0; k < TAPS; k++) begin
        case ($urandom_range(0, 2))
          0: prod.push_back($urandom_range(0, 255));
          1: prod.push_back(32'hFFFFFFFF - $urandom_range(0, 15));
          default: prod.push_back($urandom);
        endcase
      end
      run_sample(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
